// File: rtl/axis_burst_packetizer.sv
// Packetizer feeding the DDR3-backed AXI-stream virtual FIFO.
// Words arriving on a write/full interface are buffered in a small circular
// FIFO and emitted as AXI-stream packets of up to BURST_WORDS beats. Each
// packet carries a tdest chosen from the channels the vfifo is not reporting
// as full. Partial packets leave on a flush request or after an idle timeout.
module axis_burst_packetizer #(
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_WORDS    = 16,
    parameter int DEPTH_LOG2     = 5,
    parameter int FLUSH_TIMEOUT  = 64,
    parameter int ALTERNATE_DEST = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    input  logic                  flush,
    input  logic [1:0]            dest_full,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tdest,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow_err,
    input  logic                  clear_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int LW    = $clog2(BURST_WORDS + 1);
    localparam int TW    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] BURST_P = PW'(BURST_WORDS);
    localparam logic [LW-1:0] BURST_L = LW'(BURST_WORDS);
    localparam logic [TW-1:0] TMO_MAX = TW'(FLUSH_TIMEOUT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          cur_ch_q, cur_ch_d;
    logic          tdest_q, tdest_d;
    logic [LW-1:0] pkt_len_q, pkt_len_d;
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          flush_pend_q, flush_pend_d;
    logic          ovf_q, ovf_d;

    logic [PW-1:0] fill;
    logic          full_w;
    logic          wr_acc;
    logic          wr_ovf;
    logic          in_send;
    logic          hs;
    logic          last_beat;
    logic          blocked;
    logic          chosen_ch;
    logic          tmo_hit;
    logic          partial;
    logic          want_start;
    logic          start;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign full_w    = (fill == DEPTH_P);
    assign wr_acc    = write & ~full_w;
    assign wr_ovf    = write & full_w;
    assign in_send   = (state_q == ST_SEND);
    assign hs        = in_send & m_axis_tready;
    assign last_beat = (beat_cnt_q == (pkt_len_q - LW'(1)));

    // Prefer the current channel; fall back to the other one; stall if both full.
    assign blocked   = &dest_full;
    assign chosen_ch = dest_full[cur_ch_q] ? ~cur_ch_q : cur_ch_q;

    assign tmo_hit    = (FLUSH_TIMEOUT != 0) && (tmo_q == TMO_MAX);
    assign partial    = (fill != '0) && (fill < BURST_P);
    assign want_start = (fill >= BURST_P) || ((fill != '0) && (flush_pend_q || tmo_hit));
    assign start      = (state_q == ST_IDLE) && want_start && !blocked;

    // Next-state logic for pointers, error flag, timeout and packet FSM.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d     = rd_ptr_q + PW'(hs);
        cur_ch_d     = cur_ch_q;
        tdest_d      = tdest_q;
        pkt_len_d    = pkt_len_q;
        beat_cnt_d   = beat_cnt_q;
        tmo_d        = tmo_q;
        flush_pend_d = flush_pend_q;
        ovf_d        = ovf_q;

        // A same-cycle overflow beats the clear request.
        if (wr_ovf) begin
            ovf_d = 1'b1;
        end else if (clear_err) begin
            ovf_d = 1'b0;
        end

        if (start) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end

        // Idle timer only runs while a partial packet waits in IDLE; it holds
        // while both channels are blocked so the wait does not count as idle.
        if (FLUSH_TIMEOUT == 0 || start) begin
            tmo_d = '0;
        end else if ((state_q == ST_IDLE) && partial) begin
            if (!blocked && !tmo_hit) begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    pkt_len_d  = (fill >= BURST_P) ? BURST_L : LW'(fill);
                    tdest_d    = chosen_ch;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + LW'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        if (ALTERNATE_DEST != 0) begin
                            cur_ch_d = ~tdest_q;
                        end
                    end
                end
            end
        endcase
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cur_ch_q     <= 1'b0;
            tdest_q      <= 1'b0;
            pkt_len_q    <= '0;
            beat_cnt_q   <= '0;
            tmo_q        <= '0;
            flush_pend_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cur_ch_q     <= cur_ch_d;
            tdest_q      <= tdest_d;
            pkt_len_q    <= pkt_len_d;
            beat_cnt_q   <= beat_cnt_d;
            tmo_q        <= tmo_d;
            flush_pend_q <= flush_pend_d;
            ovf_q        <= ovf_d;
        end
    end

    // Buffer storage; no reset so it maps onto plain RAM.
    always_ff @(posedge aclk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_in;
        end
    end

    // Head of the buffer is presented directly (first-word-fall-through);
    // stream outputs are forced low outside SEND so reset leaves them at 0.
    assign m_axis_tvalid = in_send;
    assign m_axis_tdata  = in_send ? mem[rd_ptr_q[DEPTH_LOG2-1:0]] : '0;
    assign m_axis_tlast  = in_send & last_beat;
    assign m_axis_tdest  = in_send & tdest_q;
    assign fill_level    = fill;
    assign full          = full_w;
    assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_axis_burst_packetizer.sv
// Self-checking bench for axis_burst_packetizer: expected beats are queued
// when words are written and compared as the stream hands them over.
module tb_axis_burst_packetizer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        write;
    logic [31:0] data_in;
    logic        full;
    logic        flush;
    logic [1:0]  dest_full;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tdest;
    logic [5:0]  fill_level;
    logic        overflow_err;
    logic        clear_err;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        dest;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    axis_burst_packetizer dut (
        .aclk          (clk),
        .aresetn       (aresetn),
        .write         (write),
        .data_in       (data_in),
        .full          (full),
        .flush         (flush),
        .dest_full     (dest_full),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .fill_level    (fill_level),
        .overflow_err  (overflow_err),
        .clear_err     (clear_err)
    );

    // Watches the stream: pops expectations on handshakes, checks stability
    // under back-pressure and the idle cycle after each tlast.
    task automatic run_monitor();
        logic        prev_stall = 1'b0;
        logic        prev_last  = 1'b0;
        logic [31:0] p_data = '0;
        logic        p_last = 1'b0;
        logic        p_dest = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                prev_last  = 1'b0;
                continue;
            end
            if (prev_last) begin
                vectors++;
                if (m_axis_tvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_after_tlast: tvalid=%b required 0", m_axis_tvalid);
                end
            end
            if (prev_stall) begin
                vectors++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_data ||
                    m_axis_tlast !== p_last || m_axis_tdest !== p_dest) begin
                    miscompares++;
                    $display("FAIL stall_hold: v=%b d=%h l=%b t=%b required v=1 d=%h l=%b t=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest,
                             p_data, p_last, p_dest);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: d=%h l=%b t=%b required no beat",
                             m_axis_tdata, m_axis_tlast, m_axis_tdest);
                end else begin
                    e = sb.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tlast !== e.last ||
                        m_axis_tdest !== e.dest) begin
                        miscompares++;
                        $display("FAIL beat: d=%h l=%b t=%b required d=%h l=%b t=%b",
                                 m_axis_tdata, m_axis_tlast, m_axis_tdest,
                                 e.data, e.last, e.dest);
                    end else begin
                        $display("beat d=%h last=%b dest=%b ok", m_axis_tdata,
                                 m_axis_tlast, m_axis_tdest);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_last  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            p_data     = m_axis_tdata;
            p_last     = m_axis_tlast;
            p_dest     = m_axis_tdest;
        end
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        write         = 1'b0;
        data_in       = '0;
        flush         = 1'b0;
        dest_full     = 2'b00;
        m_axis_tready = 1'b1;
        clear_err     = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
    endtask

    task automatic push_pkt(input int base, input int len, input logic dest);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.data = 32'(base + i);
            e.last = (i == len - 1);
            e.dest = dest;
            sb.push_back(e);
        end
    endtask

    // Back-to-back writes, one per cycle; returns #1 after the last write edge.
    task automatic write_burst(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            write   = 1'b1;
            data_in = 32'(base + i);
            @(posedge clk);
            #1;
        end
        write = 1'b0;
    endtask

    task automatic wait_drain(input bit toggle, input int budget);
        int n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < budget) begin
            @(posedge clk);
            #1;
            if (toggle) m_axis_tready = ~m_axis_tready;
            n++;
        end
        m_axis_tready = 1'b1;
        vectors++;
        if (sb.size() != 0 || m_axis_tvalid) begin
            miscompares++;
            $display("FAIL drain_timeout: pending=%0d tvalid=%b required 0 and 0",
                     sb.size(), m_axis_tvalid);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdest !== 1'b0 ||
            m_axis_tdata !== 32'h0 || full !== 1'b0 || fill_level !== 6'd0 ||
            overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: v=%b l=%b t=%b d=%h f=%b lvl=%0d ov=%b required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata, full,
                     fill_level, overflow_err);
        end
        // Reset in the middle of a stalled packet.
        m_axis_tready = 1'b0;
        write_burst(100, 16);
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b0;
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || fill_level !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_mid_packet: tvalid=%b fill=%0d required 0 and 0",
                     m_axis_tvalid, fill_level);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_burst();
        do_reset();
        push_pkt(0, 16, 1'b0);
        write_burst(0, 16);
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: tvalid=%b required 0", m_axis_tvalid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_first_beat: tvalid=%b required 1", m_axis_tvalid);
        end
        wait_drain(1'b0, 60);
        vectors++;
        if (fill_level !== 6'd0) begin
            miscompares++;
            $display("FAIL single_fill_after: fill=%0d required 0", fill_level);
        end
        $display("test_single_burst done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_pkt(0, 16, 1'b0);
        push_pkt(16, 16, 1'b1);
        write_burst(0, 32);
        wait_drain(1'b0, 100);
        $display("test_back_to_back done");
    endtask

    task automatic test_flush();
        do_reset();
        push_pkt(0, 5, 1'b0);
        write_burst(0, 5);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_drain(1'b0, 20);
        $display("test_flush done");
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        do_reset();
        push_pkt(50, 5, 1'b0);
        write_burst(50, 5);
        repeat (50) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL timeout_early: tvalid seen=1 required 0 within 50 cycles");
        end
        wait_drain(1'b0, 200);
        $display("test_timeout done");
    endtask

    task automatic test_backpressure();
        do_reset();
        push_pkt(200, 16, 1'b0);
        write_burst(200, 16);
        wait_drain(1'b1, 120);
        $display("test_backpressure done");
    endtask

    task automatic test_dest_full();
        bit seen = 1'b0;
        do_reset();
        dest_full = 2'b01;
        push_pkt(300, 16, 1'b1);
        write_burst(300, 16);
        wait_drain(1'b0, 60);
        do_reset();
        dest_full = 2'b11;
        write_burst(400, 16);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL both_blocked: tvalid seen=1 required 0");
        end
        push_pkt(400, 16, 1'b0);
        dest_full = 2'b10;
        wait_drain(1'b0, 60);
        $display("test_dest_full done");
    endtask

    task automatic test_overflow();
        do_reset();
        m_axis_tready = 1'b0;
        write_burst(0, 32);
        vectors++;
        if (full !== 1'b1 || fill_level !== 6'd32 || overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_at_32: full=%b fill=%0d ov=%b required 1 32 0",
                     full, fill_level, overflow_err);
        end
        write_burst(999, 1);
        vectors++;
        if (overflow_err !== 1'b1 || fill_level !== 6'd32) begin
            miscompares++;
            $display("FAIL overflow_set: ov=%b fill=%0d required 1 32", overflow_err, fill_level);
        end
        write     = 1'b1;
        data_in   = 32'd998;
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        vectors++;
        if (overflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_beats_clear: ov=%b required 1", overflow_err);
        end
        @(posedge clk);
        #1 clear_err = 1'b0;
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_err: ov=%b required 0", overflow_err);
        end
        push_pkt(0, 16, 1'b0);
        push_pkt(16, 16, 1'b1);
        m_axis_tready = 1'b1;
        wait_drain(1'b0, 100);
        $display("test_overflow done");
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_backpressure();
        test_dest_full();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_burst_packetizer.md
Name: axis_burst_packetizer

Overview:
- Upstream feeder stage for the DDR3-backed AXI-stream virtual FIFO.
- Accepts 32-bit words on a generic write/full interface and buffers them in a small internal FIFO.
- Emits AXI-stream packets of at most BURST_WORDS beats, with tlast and a per-packet tdest, into the vfifo slave port.
- Short packets are flushed on request or after an idle timeout. Destination channels reported full by the vfifo are skipped.

Parameters:
DATA_WIDTH, 32, word and tdata width
BURST_WORDS, 16, maximum beats per packet (64-byte burst / 4-byte bus)
DEPTH_LOG2, 5, internal buffer depth = 2**DEPTH_LOG2 words; must be >= log2(BURST_WORDS)+1
FLUSH_TIMEOUT, 64, idle cycles with a partial packet before forced emit; 0 disables
ALTERNATE_DEST, 1, 1 = toggle tdest after each packet; 0 = always channel 0 unless full

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
write  in  1  write strobe, one word per cycle
data_in  in  DATA_WIDTH  write data
full  out  1  buffer full; writes while high are dropped
flush  in  1  pulse: emit any partial packet at next opportunity
dest_full  in  2  vfifo s2mm channel-full flags, bit n = channel n
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tlast  out  1  last beat of packet
m_axis_tdest  out  1  destination channel
fill_level  out  DEPTH_LOG2+1  words currently buffered
overflow_err  out  1  sticky: write attempted while full
clear_err  in  1  synchronous clear of overflow_err

Behaviour:
- Reset (async assert, sync release): all outputs 0, pointers 0, state IDLE, current channel 0, timeout counter 0, flush_pending 0.
- Buffer: circular, pointers DEPTH_LOG2+1 bits wide, wrap naturally.
  - full = (fill_level == 2**DEPTH_LOG2).
  - A write while full is dropped and sets overflow_err, even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop leaves fill_level unchanged.
- overflow_err: clear_err clears it; a same-cycle overflow wins (bit stays set).
- flush_pending: set by flush, cleared when a packet starts.
- Timeout counter:
  - Increments each IDLE cycle while 0 < fill_level < BURST_WORDS.
  - Reset to 0 otherwise and on packet start; saturates.
  - Reaching FLUSH_TIMEOUT = timeout event.
- State IDLE:
  - Start condition: fill_level >= BURST_WORDS, or (fill_level > 0 and (flush_pending or timeout event)).
  - Channel choice: current channel if its dest_full bit is 0; else the other channel if its bit is 0; else stay IDLE, with no timeout increment while both channels are blocked.
  - On start: latch pkt_len = min(fill_level, BURST_WORDS) and latch tdest; go to SEND.
- State SEND:
  - m_axis_tvalid=1.
  - tdata is the buffer head (first-word-fall-through).
  - tlast=1 when beat_cnt == pkt_len-1.
  - tdest is constant for the whole packet; dest_full changes mid-packet are ignored.
  - A beat transfers only when tvalid&tready. While tready=0, tdata, tlast and tdest are held stable.
  - On the tlast handshake: tvalid=0 next cycle; if ALTERNATE_DEST, the current channel becomes ~tdest; go to IDLE.
- Latency: the earliest first beat is 2 cycles after the write that completes BURST_WORDS. There is one idle cycle between packets.
- Words written during SEND are buffered only; they never extend the packet in flight.
- pkt_len is always >= 1, so zero-length packets never occur.
- Reset mid-packet discards buffered data; no tlast is emitted.

Test Plan:
- 16 consecutive writes 0..15, tready=1 -> one packet of 16 beats, data 0..15, tlast only on beat 15, tdest=0; fill_level returns to 0.
- 32 writes, tready=1, ALTERNATE_DEST=1 -> two packets: data 0..15 with tdest=0, then 16..31 with tdest=1.
- 5 writes then flush pulse -> 5-beat packet, tlast on 5th beat; repeat with no flush -> packet emitted after 64 idle cycles.
- tready toggling 1010... during a 16-beat packet -> all 16 words delivered in order; tdata/tlast/tdest stable whenever tvalid=1 and tready=0.
- dest_full=2'b01, 16 writes -> packet goes out on tdest=1; dest_full=2'b11 -> no tvalid until a bit clears, then packet emitted.
- tready=0, 33 writes -> full=1 after 32 writes, 33rd dropped, overflow_err=1; clear_err -> 0; releasing tready -> words 0..31 delivered in two 16-beat packets.
